// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle for the bit-serial adder sequencer.
//   start : request strobe, accepted only while the sequencer is idle
//   a, b  : WIDTH-bit operands, sampled on the accepting edge
//   cin   : carry-in, sampled on the accepting edge
//   busy  : high while an addition is running or completing
//   done  : one-cycle pulse, sum/cout valid
//   sum   : registered WIDTH-bit result, held until the next completion
//   cout  : registered carry-out, held with sum
// modport master drives the request side, modport slave is the sequencer.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial WIDTH-bit adder sequencer. One full adder (two half adders plus
// an OR) and a carry flop process the operands LSB-first, one bit per clock.
//   clk     : clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : serial_add_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// Timing: start accepted at edge k, bits at edges k+1..k+WIDTH, done high for
// the cycle after edge k+WIDTH, back to idle after edge k+WIDTH+1.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_add_ctrl_if.slave   bus
);

  // Counter is one bit wider than clog2 so WIDTH=1 still gets a 1-bit counter.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Half adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder from two half-adder cells and an OR: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], ci);
    return {h0[1] | h1[1], h1[0]};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sa_nxt_s;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sb_nxt_s;
  logic             cy_r;
  logic             cy_nxt_s;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt_s;
  logic             cout_r;
  logic             cout_nxt_s;
  logic [1:0]       fa_s;
  logic [WIDTH-1:0] res_shift_s;

  // Next-state and datapath decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    sa_nxt_s    = sa_r;
    sb_nxt_s    = sb_r;
    cy_nxt_s    = cy_r;
    res_nxt_s   = res_r;
    cnt_nxt_s   = cnt_r;
    sum_nxt_s   = sum_r;
    cout_nxt_s  = cout_r;

    fa_s = full_add(sa_r[0], sb_r[0], cy_r);
    // New sum bit enters at the MSB; after WIDTH bits the LSB-first stream
    // lines up with bit 0.
    res_shift_s              = res_r >> 1'b1;
    res_shift_s[WIDTH-1]     = fa_s[0];

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          sa_nxt_s    = bus.a;
          sb_nxt_s    = bus.b;
          cy_nxt_s    = bus.cin;
          cnt_nxt_s   = '0;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        sa_nxt_s  = sa_r >> 1'b1;
        sb_nxt_s  = sb_r >> 1'b1;
        cy_nxt_s  = fa_s[1];
        res_nxt_s = res_shift_s;
        if (cnt_r == LAST_CNT) begin
          // Counter parks at zero so it never exceeds WIDTH-1.
          cnt_nxt_s   = '0;
          sum_nxt_s   = res_shift_s;
          cout_nxt_s  = fa_s[1];
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      sa_r    <= '0;
      sb_r    <= '0;
      cy_r    <= 1'b0;
      res_r   <= '0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sa_r    <= sa_nxt_s;
      sb_r    <= sb_nxt_s;
      cy_r    <= cy_nxt_s;
      res_r   <= res_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sum_r   <= sum_nxt_s;
      cout_r  <= cout_nxt_s;
    end
  end

  // Status is decoded from the state register only; no input reaches an output.
  assign bus.busy = (state_r == ST_RUN) || (state_r == ST_DONE);
  assign bus.done = (state_r == ST_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Drives an 8-bit and a 1-bit serial_add_ctrl through a vector table, the
// multi-cycle corner sequences (ignored START, mid-run reset, held START) and
// random operands compared against plain integer addition.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One 8-bit transaction from idle: latency, result and return to idle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] exp_sum, input logic exp_cout, input string name);
    int cyc;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    @(negedge clk);  // accepting edge k has passed
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    chk({name, "_busy_k"}, 64'(bus8.busy), 64'd1);
    chk({name, "_done_k"}, 64'(bus8.done), 64'd0);
    cyc = 0;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, 64'(cyc), 64'd8);
    chk({name, "_sum"}, 64'(bus8.sum), 64'(exp_sum));
    chk({name, "_cout"}, 64'(bus8.cout), 64'(exp_cout));
    @(negedge clk);
    chk({name, "_done_end"}, 64'(bus8.done), 64'd0);
    chk({name, "_busy_end"}, 64'(bus8.busy), 64'd0);
  endtask

  // One 1-bit transaction from idle.
  task automatic op1(input logic a, input logic b, input logic cin, input logic [1:0] exp, input string name);
    int cyc;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = cin;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.a     = ~a;
    bus1.b     = ~b;
    bus1.cin   = ~cin;
    cyc = 0;
    while (bus1.done !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, 64'(cyc), 64'd1);
    chk({name, "_res"}, 64'({bus1.cout, bus1.sum}), 64'(exp));
    @(negedge clk);
    chk({name, "_busy_end"}, 64'(bus1.busy), 64'd0);
  endtask

  initial begin
    vec_t        tbl [5];
    int          ndone;
    int          last_done;
    int          cyc;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;
    logic [8:0]  rexp;
    logic [1:0]  e1;

    total = 0;
    bad   = 0;
    tbl[0] = '{a: 8'h05, b: 8'h03, cin: 1'b0, sum: 8'h08, cout: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
    tbl[4] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};

    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.cin = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus8.busy), 64'd0);
    chk("rst_done", 64'(bus8.done), 64'd0);
    chk("rst_sum",  64'(bus8.sum),  64'd0);
    chk("rst_cout", 64'(bus8.cout), 64'd0);
    chk("rst1_res", 64'({bus1.cout, bus1.sum, bus1.busy}), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, $sformatf("tbl%0d", i));
    end

    // START during RUN is ignored; exactly one DONE with the first result.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    @(negedge clk);  // after edge k
    bus8.start = 1'b0; bus8.a = 8'hAA; bus8.b = 8'h55;
    repeat (2) @(negedge clk);  // after edge k+2
    bus8.start = 1'b1;          // sampled at edge k+3
    @(negedge clk);
    bus8.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) ndone++;
    end
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_sum",   64'(bus8.sum), 64'h46);
    chk("ign_cout",  64'(bus8.cout), 64'd0);
    chk("ign_busy",  64'(bus8.busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("ign_hold",  64'(bus8.sum), 64'h46);

    // Reset at edge k+4 abandons the run and clears the result.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);  // after edge k+3
    reset_n = 1'b0;
    @(negedge clk);             // after edge k+4
    chk("mrst_busy", 64'(bus8.busy), 64'd0);
    chk("mrst_done", 64'(bus8.done), 64'd0);
    chk("mrst_sum",  64'(bus8.sum),  64'd0);
    chk("mrst_cout", 64'(bus8.cout), 64'd0);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) ndone++;
    end
    chk("mrst_nodone", 64'(ndone), 64'd0);
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "mrst_after");

    // START held high: re-arms every WIDTH+2 cycles.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;
    ndone = 0;
    last_done = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        ndone++;
        chk($sformatf("hold_sum%0d", ndone), 64'(bus8.sum), 64'h02);
        if (last_done >= 0) chk($sformatf("hold_gap%0d", ndone), 64'(i - last_done), 64'd10);
        last_done = i;
      end
    end
    chk("hold_ndone", 64'(ndone), 64'd3);
    bus8.start = 1'b0;
    cyc = 0;
    while (bus8.busy !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold_idle", 64'(bus8.busy), 64'd0);

    // WIDTH=1: exhaustive operand/carry combinations.
    for (int i = 0; i < 8; i++) begin
      e1 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      op1(i[2], i[1], i[0], e1, $sformatf("w1_%0d", i));
    end

    // Random operands against integer addition.
    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op8(ra, rb, rc, rexp[7:0], rexp[8], $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
